// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-ROM stream loader: FSM states and failure codes.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/irom_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface irom_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Collects stream bytes little-endian; word and word_valid are presented combinationally
// with the fourth byte so the memory write can be registered on that same edge.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 2'd0;
      shreg <= 24'd0;
    end else if (clr) begin
      cnt   <= 2'd0;
    end else if (byte_en) begin
      cnt   <= cnt + 2'd1;
      shreg <= {byte_in, shreg[23:8]};
    end
  end

  assign word       = {byte_in, shreg};
  assign word_valid = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/irom_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the CPU in reset until a load completes with a good checksum.
module irom_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  irom_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_e            state, state_nxt;
  logic              accept;
  logic              clr;
  logic              wr_nxt;
  logic [1:0]        err_code_nxt;
  logic [7:0]        len_lo;
  logic [15:0]       len_in;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   wcnt;
  logic [ADDR_W:0]   wcnt_inc;
  logic [7:0]        csum;
  logic [DATA_W-1:0] word;
  logic              word_valid;

  assign accept   = bus.in_valid && bus.in_ready;
  assign len_in   = {bus.in_data, len_lo};
  assign wcnt_inc = wcnt + {{ADDR_W{1'b0}}, 1'b1};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .byte_en    (accept && (state == DATA)),
    .byte_in    (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nxt    = state;
    clr          = 1'b0;
    wr_nxt       = 1'b0;
    err_code_nxt = err_code;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt    = LEN_LO;
          clr          = 1'b1;
          err_code_nxt = ERR_NONE;
        end
      end
      LEN_LO: if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_in} > DEPTH) begin
            state_nxt    = ERROR;
            err_code_nxt = ERR_LEN;
          end else if (len_in == 16'd0) begin
            state_nxt = CHECK;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        // The last word's write cycle is already spent in CHECK.
        if (word_valid) begin
          wr_nxt = 1'b1;
          if (wcnt_inc == len) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          if (bus.in_data == csum) begin
            state_nxt = DONE;
          end else begin
            state_nxt    = ERROR;
            err_code_nxt = ERR_CSUM;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= ERR_NONE;
      len_lo        <= 8'd0;
      len           <= '0;
      wcnt          <= '0;
      csum          <= 8'd0;
    end else begin
      state         <= state_nxt;
      bus.in_ready  <= ((state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                        (state_nxt == DATA)   || (state_nxt == CHECK)) && !wr_nxt;
      bus.mem_we    <= wr_nxt;
      cpu_hold      <= (state_nxt != DONE);
      done          <= (state_nxt == DONE);
      err           <= (state_nxt == ERROR);
      err_code      <= err_code_nxt;
      if (clr) begin
        wcnt         <= '0;
        csum         <= 8'd0;
        len          <= '0;
        bus.mem_addr <= '0;
      end
      if (accept && (state == LEN_LO)) len_lo <= bus.in_data;
      if (accept && (state == LEN_HI)) len <= len_in[ADDR_W:0];
      if (accept && (state == DATA)) csum <= csum ^ bus.in_data;
      if (wr_nxt) begin
        bus.mem_addr  <= wcnt[ADDR_W-1:0];
        bus.mem_wdata <= word;
        wcnt          <= wcnt_inc;
      end
    end
  end

endmodule
